// File: rtl/mdu_pkg.sv
// Shared op and state encodings for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  // MADD/MSUB take one code each; the interface op_u bit selects MADDU/MSUBU.
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;

  function automatic logic op_signed(input logic [2:0] op, input logic op_u);
    case (op)
      OP_MULT, OP_DIV:  return 1'b1;
      OP_MADD, OP_MSUB: return ~op_u;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage (master) and muldiv_unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             op_u;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_u, rs, rt,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, op_u, rs, rt,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mdu_divider.sv
// Iterative restoring unsigned divider: one quotient bit per i_step, WIDTH steps after i_load.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH:0]   w_trial;

  // r_quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dsr};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dsr <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dsr <= i_divisor;
    end else if (i_step) begin
      if (!w_trial[WIDTH]) begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV engine owning the HI/LO pair. Define MULDIV_MADD_EN to add
// MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 1
) (
  input  logic         CLK,
  input  logic         RST,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2((WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_hi, r_lo, w_hi_next, w_lo_next;
  logic               r_done, w_done_next, r_div0, w_div0_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_sgn;
  acc_e               r_acc, w_acc_next;
  logic               w_latch, w_div_load, w_div_step, w_op_sgn;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_quo_fix, w_rem_fix;
  logic               w_neg_q, w_neg_r;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_mul_result;

  assign w_op_sgn = op_signed(bus.op, bus.op_u);
  assign w_mag_a  = (w_op_sgn && bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
  assign w_mag_b  = (w_op_sgn && bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .CLK         (CLK),
    .RST         (RST),
    .i_load      (w_div_load),
    .i_step      (w_div_step),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // Signs come from the latched original operands; remainder follows the dividend.
  assign w_neg_q   = r_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_neg_r   = r_sgn & r_a[WIDTH-1];
  assign w_quo_fix = w_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = w_neg_r ? -w_rem : w_rem;

  // Product of registered operands; a multicycle path of MUL_CYCLES edges.
  assign w_a_ext = {{WIDTH{r_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{r_sgn & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_comb begin
    w_mul_result = w_prod;
    case (r_acc)
      ACC_ADD: w_mul_result = {r_hi, r_lo} + w_prod;
      ACC_SUB: w_mul_result = {r_hi, r_lo} - w_prod;
      default: w_mul_result = w_prod;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_done_next  = 1'b0;
    w_div0_next  = 1'b0;
    w_cnt_next   = r_cnt;
    w_acc_next   = r_acc;
    w_latch      = 1'b0;
    w_div_load   = 1'b0;
    w_div_step   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MTHI: w_hi_next = bus.rs;
            OP_MTLO: w_lo_next = bus.rs;
            OP_MULT, OP_MULTU: begin
              w_latch      = 1'b1;
              w_acc_next   = ACC_NONE;
              w_cnt_next   = '0;
              w_state_next = MUL;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD: begin
              w_latch      = 1'b1;
              w_acc_next   = ACC_ADD;
              w_cnt_next   = '0;
              w_state_next = MUL;
            end
            OP_MSUB: begin
              w_latch      = 1'b1;
              w_acc_next   = ACC_SUB;
              w_cnt_next   = '0;
              w_state_next = MUL;
            end
`endif
            OP_DIV, OP_DIVU: begin
              if (bus.rt == '0) begin
                w_done_next = 1'b1;
                w_div0_next = 1'b1;
              end else begin
                w_latch      = 1'b1;
                w_div_load   = 1'b1;
                w_cnt_next   = '0;
                w_state_next = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (r_cnt == MUL_LAST) begin
          {w_hi_next, w_lo_next} = w_mul_result;
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DIV: begin
        w_div_step = 1'b1;
        if (r_cnt == DIV_LAST) w_state_next = FIX;
        else                   w_cnt_next   = r_cnt + 1'b1;
      end
      FIX: begin
        w_hi_next    = w_rem_fix;
        w_lo_next    = w_quo_fix;
        w_done_next  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sgn  <= 1'b0;
      r_acc  <= ACC_NONE;
    end else begin
      r_hi   <= w_hi_next;
      r_lo   <= w_lo_next;
      r_done <= w_done_next;
      r_div0 <= w_div0_next;
      r_cnt  <= w_cnt_next;
      r_acc  <= w_acc_next;
      if (w_latch) begin
        r_a   <= bus.rs;
        r_b   <= bus.rt;
        r_sgn <= w_op_sgn;
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS datapath.
- Sits beside the EX-stage ALU. EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start pulse and reads HI/LO for MFHI/MFLO.
- The control path stalls on `busy`. This replaces single-cycle multiply/divide with a WIDTH-generic multi-cycle engine, a latency-configurable multiplier and an iterative divider.

Parameters:
- WIDTH, 32, operand and HI/LO width. Must be even and at least 8.
- MUL_CYCLES, 1, multiply latency in cycles (at least 1). Models a retimed or pipelined multiplier.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  issue strobe; sampled only when busy=0
- op  in  3  operation code (mdu_pkg encoding)
- rs  in  WIDTH  operand A: dividend, multiplicand, or MTHI/MTLO source
- rt  in  WIDTH  operand B: divisor or multiplier
- busy  out  1  operation in flight; HI/LO are not valid to read
- done  out  1  one-cycle pulse after HI/LO are written by MUL or DIV
- div0  out  1  one-cycle pulse, concurrent with done, when the divisor is 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, div0=0. Reset asserted mid-operation aborts the operation; HI/LO are cleared and no done is issued.
- States: IDLE, MUL, DIV, FIX.
  - done and div0 default to 0 every cycle.
  - busy=1 exactly when state is not IDLE.
- Edge k, state=IDLE, start=1, behaviour by op:
  - MTHI: hi<=rs. MTLO: lo<=rs. State stays IDLE, no done pulse.
  - MULT/MULTU: latch operands, go to MUL.
    - Product is 2*WIDTH bits, signed or unsigned per op.
    - After MUL_CYCLES edges in MUL, {hi,lo}<=product and the unit returns to IDLE.
    - done=1 in the following cycle, with busy=0.
  - DIV/DIVU with rt=0: HI/LO unchanged. Next cycle done=1, div0=1, state IDLE, and busy is never raised.
  - DIV/DIVU with rt!=0: go to DIV.
    - Operands are converted to magnitudes (signed op only).
    - Restoring radix-2 division, one quotient bit per edge, WIDTH edges.
    - Then FIX for one edge: apply signs, write lo<=quotient and hi<=remainder, return to IDLE.
    - Busy cycles = WIDTH+1. done is asserted in cycle k+WIDTH+2.
  - Undefined op: ignored.
- Signed division:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN_INT / -1 gives lo=MIN_INT (wrap) and hi=0.
- start while busy=1 is ignored with no queuing. The issuer must hold the instruction until busy=0.
- HI/LO change only on: MTHI/MTLO, the final MUL edge, the FIX edge, or reset.
- hi/lo are driven directly from registers, with no combinational path from inputs.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: op adds MADD, MADDU, MSUB and MSUBU.
  - Same MUL timing as MULT.
  - Final edge: {hi,lo} <= {hi,lo} ± product, modulo 2^(2*WIDTH), signed or unsigned per op.
- Undefined: these encodings are treated as undefined ops and ignored.

Decomposition:
- Shared package mdu_pkg:
  - op encoding constants: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5, OP_MADD=6, OP_MSUB=7. MADDU and MSUBU use OP_MADD/OP_MSUB plus an unsigned qualifier bit, decided in the package.
  - state encoding.
- Sub-module mdu_divider: iterative restoring unsigned divider core (load, step, quotient/remainder), WIDTH-parametrised. Sign handling and the FSM stay in muldiv_unit.

Test Plan (WIDTH=32):
- MULT rs=FFFFFFFD (-3), rt=5 -> after MUL_CYCLES, hi=FFFFFFFF, lo=FFFFFFF1; done pulse 1 cycle. Repeat with MUL_CYCLES=3 and check busy is high for exactly 3 cycles.
- MULTU rs=rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV rs=FFFFFFF9 (-7), rt=2 -> busy high 33 cycles, then lo=FFFFFFFD, hi=FFFFFFFF. DIVU 100/7 -> lo=0000000E, hi=00000002.
- DIV rs=80000000, rt=FFFFFFFF -> lo=80000000, hi=0. DIVU rt=0 with prior hi=11, lo=22 -> div0=1, done=1, hi/lo still 11/22, busy never high.
- Start DIV, pulse start=1 with MTHI at cycle 5 (ignored), assert RST at cycle 10 -> hi=lo=0, busy=0, no done. MTHI 1234 afterwards -> hi=1234 next cycle.
- With MULDIV_MADD_EN: hi=0, lo=FFFFFFFF, MADDU 1*1 -> hi=1, lo=0. MSUB 1*1 -> hi=0, lo=FFFFFFFF.
